alu_op_sequencer: RTL and testbench

- Control-side counterpart of the datapath: generates, cycle by cycle, the bus-select, register-write and ALU-select strobes that the datapath consumes.
- Executes one register-register ALU instruction per start request: Rb->RY, then Rc on bus with op select capturing Z, then write-back.
- Sits between the instruction decode logic and the datapath control inputs.

---
 rtl/alu_op_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// ============================================================================
// alu_op_sequencer : per-cycle datapath strobes for one register-register ALU op
// Optional build macro SEQ_R0_GUARD_EN: write-back to register 0 is suppressed.
// Revision 1.0
// ============================================================================
`default_nettype none

module alu_op_sequencer #(
    parameter int NREG     = 16,
    parameter int ALU_WAIT = 0
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            start,
    input  logic [3:0]      opcode,
    input  logic [3:0]      ra,
    input  logic [3:0]      rb,
    input  logic [3:0]      rc,
    output logic [NREG-1:0] reg_select,
    output logic            RY_select_write,
    output logic [12:0]     alu_select,
    output logic            ZHI_select_write,
    output logic            ZLO_select_write,
    output logic            ZHI_select,
    output logic            ZLO_select,
    output logic            HI_select_write,
    output logic            LO_select_write,
    output logic            RF_enable,
    output logic [3:0]      RF_write,
    output logic            busy,
    output logic            done,
    output logic            illegal
);

    localparam logic [3:0] OP_MUL    = 4'd4;
    localparam logic [3:0] OP_DIV    = 4'd5;
    localparam logic [3:0] OP_NEG    = 4'd11;
    localparam logic [3:0] OP_NOT    = 4'd12;
    localparam logic [3:0] OP_LAST   = 4'd12;
    localparam logic [3:0] WAIT_INIT = 4'(ALU_WAIT);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOADY = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_WB    = 3'd3;
    localparam logic [2:0] ST_MVHI  = 3'd4;
    localparam logic [2:0] ST_MVLO  = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    logic [2:0] state_q, state_d;
    logic [3:0] wait_q,  wait_d;
    logic [3:0] op_q, ra_q, rb_q, rc_q;

    logic w_accept;
    logic w_in_illegal, w_in_unary;
    logic w_muldiv, w_unary, w_illegal;
    logic w_exec_last;

    function automatic logic [NREG-1:0] onehot_reg(input logic [3:0] idx);
        logic [NREG-1:0] v;
        v = '0;
        for (int i = 0; i < NREG; i++) begin
            if (int'(idx) == i) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    assign w_accept     = (state_q == ST_IDLE) && start;
    assign w_in_illegal = (opcode > OP_LAST);
    assign w_in_unary   = (opcode == OP_NEG) || (opcode == OP_NOT);

    assign w_muldiv     = (op_q == OP_MUL) || (op_q == OP_DIV);
    assign w_unary      = (op_q == OP_NEG) || (op_q == OP_NOT);
    assign w_illegal    = (op_q > OP_LAST);
    assign w_exec_last  = (wait_q == 4'd0);

    // State, wait counter and the instruction fields captured at acceptance.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            wait_q  <= 4'd0;
            op_q    <= 4'd0;
            ra_q    <= 4'd0;
            rb_q    <= 4'd0;
            rc_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (w_accept) begin
                op_q <= opcode;
                ra_q <= ra;
                rb_q <= rb;
                rc_q <= rc;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (w_in_illegal) begin
                        state_d = ST_DONE;
                    end else if (w_in_unary) begin
                        // NEG/NOT are never slow ops, so EXEC is a single cycle.
                        state_d = ST_EXEC;
                        wait_d  = 4'd0;
                    end else begin
                        state_d = ST_LOADY;
                    end
                end
            end
            ST_LOADY: begin
                state_d = ST_EXEC;
                wait_d  = w_muldiv ? WAIT_INIT : 4'd0;
            end
            ST_EXEC: begin
                if (w_exec_last) begin
                    state_d = w_muldiv ? ST_MVHI : ST_WB;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_WB:   state_d = ST_DONE;
            ST_MVHI: state_d = ST_MVLO;
            ST_MVLO: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: begin
                state_d = ST_IDLE;
                wait_d  = 4'd0;
            end
        endcase
    end

    // Strobes depend only on registered state, so there is no input-to-output path.
    always_comb begin
        reg_select       = '0;
        RY_select_write  = 1'b0;
        alu_select       = '0;
        ZHI_select_write = 1'b0;
        ZLO_select_write = 1'b0;
        ZHI_select       = 1'b0;
        ZLO_select       = 1'b0;
        HI_select_write  = 1'b0;
        LO_select_write  = 1'b0;
        RF_enable        = 1'b0;
        RF_write         = 4'd0;
        busy             = (state_q != ST_IDLE);
        done             = 1'b0;
        illegal          = 1'b0;
        case (state_q)
            ST_LOADY: begin
                reg_select      = onehot_reg(rb_q);
                RY_select_write = 1'b1;
            end
            ST_EXEC: begin
                reg_select = onehot_reg(w_unary ? rb_q : rc_q);
                if (!w_illegal) begin
                    alu_select = 13'd1 << op_q;
                end
                ZHI_select_write = w_exec_last;
                ZLO_select_write = w_exec_last;
            end
            ST_WB: begin
                ZLO_select = 1'b1;
`ifdef SEQ_R0_GUARD_EN
                if (ra_q != 4'd0) begin
                    RF_enable = 1'b1;
                    RF_write  = ra_q;
                end
`else
                RF_enable = 1'b1;
                RF_write  = ra_q;
`endif
            end
            ST_MVHI: begin
                ZHI_select      = 1'b1;
                HI_select_write = 1'b1;
            end
            ST_MVLO: begin
                ZLO_select      = 1'b1;
                LO_select_write = 1'b1;
            end
            ST_DONE: begin
                done    = 1'b1;
                illegal = w_illegal;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: table of instructions, expected strobe traces via a queue.
`default_nettype none

module tb_alu_op_sequencer;

    localparam int NREG = 16;
    localparam int W    = 2;

    logic clk = 1'b0;
    logic clr = 1'b0;
    logic start = 1'b0;
    logic [3:0] opcode = '0, ra = '0, rb = '0, rc = '0;

    logic [NREG-1:0] reg_select;
    logic RY_select_write, ZHI_select_write, ZLO_select_write;
    logic ZHI_select, ZLO_select, HI_select_write, LO_select_write;
    logic RF_enable, busy, done, illegal;
    logic [12:0] alu_select;
    logic [3:0]  RF_write;

    alu_op_sequencer #(.NREG(NREG), .ALU_WAIT(W)) dut (
        .clk(clk), .clr(clr), .start(start), .opcode(opcode),
        .ra(ra), .rb(rb), .rc(rc),
        .reg_select(reg_select), .RY_select_write(RY_select_write),
        .alu_select(alu_select), .ZHI_select_write(ZHI_select_write),
        .ZLO_select_write(ZLO_select_write), .ZHI_select(ZHI_select),
        .ZLO_select(ZLO_select), .HI_select_write(HI_select_write),
        .LO_select_write(LO_select_write), .RF_enable(RF_enable),
        .RF_write(RF_write), .busy(busy), .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] rs;
        logic        ryw;
        logic [12:0] alu;
        logic        zhw, zlw, zhs, zls, hiw, low, rfe;
        logic [3:0]  rfw;
        logic        busy, done, ill;
    } obs_t;

    typedef struct {
        logic [3:0] op, a, b, c;
        int         lat;
    } vec_t;

    obs_t act;
    assign act = {reg_select, RY_select_write, alu_select, ZHI_select_write,
                  ZLO_select_write, ZHI_select, ZLO_select, HI_select_write,
                  LO_select_write, RF_enable, RF_write, busy, done, illegal};

    obs_t expq[$];
    int total = 0;
    int bad   = 0;
    int cyc;
    int done_cyc;

    task automatic check(input string name, input obs_t e);
        total++;
        if (act !== e) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, e);
        end
    endtask

    // Expected per-cycle outputs after acceptance, ending with one idle cycle.
    task automatic push_trace(input logic [3:0] op, a, b, c);
        obs_t o;
        logic [15:0] one16;
        logic [12:0] one13;
        int n;
        bit unary, muldiv;
        one16  = 16'h0001;
        one13  = 13'h0001;
        unary  = (op == 4'd11) || (op == 4'd12);
        muldiv = (op == 4'd4) || (op == 4'd5);
        if (op >= 4'd13) begin
            o = '0; o.busy = 1; o.done = 1; o.ill = 1;
            expq.push_back(o);
        end else begin
            if (!unary) begin
                o = '0; o.busy = 1; o.rs = one16 << b; o.ryw = 1;
                expq.push_back(o);
            end
            n = muldiv ? 1 + W : 1;
            for (int k = 0; k < n; k++) begin
                o = '0; o.busy = 1;
                o.rs  = one16 << (unary ? b : c);
                o.alu = one13 << op;
                if (k == n - 1) begin
                    o.zhw = 1; o.zlw = 1;
                end
                expq.push_back(o);
            end
            if (muldiv) begin
                o = '0; o.busy = 1; o.zhs = 1; o.hiw = 1; expq.push_back(o);
                o = '0; o.busy = 1; o.zls = 1; o.low = 1; expq.push_back(o);
            end else begin
                o = '0; o.busy = 1; o.zls = 1;
`ifdef SEQ_R0_GUARD_EN
                if (a != 4'd0) begin
                    o.rfe = 1; o.rfw = a;
                end
`else
                o.rfe = 1; o.rfw = a;
`endif
                expq.push_back(o);
            end
            o = '0; o.busy = 1; o.done = 1;
            expq.push_back(o);
        end
        expq.push_back('0);
    endtask

    // Called right after a falling edge with the DUT idle.
    task automatic run(input logic [3:0] op, a, b, c, input int lat, input bit hold);
        opcode = op; ra = a; rb = b; rc = c; start = 1'b1;
        push_trace(op, a, b, c);
        if (hold) expq.push_back('0);
        cyc = 0;
        done_cyc = -1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        opcode = 4'($urandom); ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom);
        while (expq.size() > 0) begin
            @(negedge clk);
            cyc++;
            if (act.done && done_cyc < 0) done_cyc = cyc;
            check(hold ? "trace_hold" : "trace", expq.pop_front());
            if (cyc == lat + 1) start = 1'b0;
        end
        start = 1'b0;
        total++;
        if (done_cyc != lat) begin
            bad++;
            $display("FAIL latency op=%0d got=%0d want=%0d", op, done_cyc, lat);
        end
    endtask

    vec_t vt[16];

    initial begin
        vt[0]  = '{op: 4'd0,  a: 4'd3,  b: 4'd1,  c: 4'd2,  lat: 4};
        vt[1]  = '{op: 4'd4,  a: 4'd9,  b: 4'd4,  c: 4'd5,  lat: 5 + W};
        vt[2]  = '{op: 4'd12, a: 4'd6,  b: 4'd7,  c: 4'd2,  lat: 3};
        vt[3]  = '{op: 4'd14, a: 4'd1,  b: 4'd2,  c: 4'd3,  lat: 1};
        vt[4]  = '{op: 4'd2,  a: 4'd0,  b: 4'd8,  c: 4'd9,  lat: 4};
        vt[5]  = '{op: 4'd1,  a: 4'd15, b: 4'd0,  c: 4'd15, lat: 4};
        vt[6]  = '{op: 4'd3,  a: 4'd10, b: 4'd11, c: 4'd11, lat: 4};
        vt[7]  = '{op: 4'd5,  a: 4'd2,  b: 4'd12, c: 4'd13, lat: 5 + W};
        vt[8]  = '{op: 4'd6,  a: 4'd4,  b: 4'd14, c: 4'd3,  lat: 4};
        vt[9]  = '{op: 4'd7,  a: 4'd5,  b: 4'd6,  c: 4'd7,  lat: 4};
        vt[10] = '{op: 4'd8,  a: 4'd7,  b: 4'd9,  c: 4'd1,  lat: 4};
        vt[11] = '{op: 4'd9,  a: 4'd8,  b: 4'd3,  c: 4'd0,  lat: 4};
        vt[12] = '{op: 4'd10, a: 4'd11, b: 4'd5,  c: 4'd6,  lat: 4};
        vt[13] = '{op: 4'd11, a: 4'd12, b: 4'd15, c: 4'd4,  lat: 3};
        vt[14] = '{op: 4'd13, a: 4'd13, b: 4'd1,  c: 4'd1,  lat: 1};
        vt[15] = '{op: 4'd15, a: 4'd14, b: 4'd2,  c: 4'd8,  lat: 1};

        cyc = 0;
        #3;
        check("reset_outputs", '0);
        @(negedge clk);
        clr = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run(vt[i].op, vt[i].a, vt[i].b, vt[i].c, vt[i].lat, 1'b0);
        end

        // Asynchronous reset in the middle of an ADD's EXEC cycle.
        opcode = 4'd2; ra = 4'd5; rb = 4'd1; rc = 4'd2; start = 1'b1;
        push_trace(4'd2, 4'd5, 4'd1, 4'd2);
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        repeat (2) begin
            @(negedge clk);
            cyc++;
            check("rst_pre", expq.pop_front());
        end
        clr = 1'b0;
        #1;
        check("rst_async", '0);
        expq.delete();
        repeat (3) begin
            @(negedge clk);
            cyc++;
            check("rst_held", '0);
        end
        clr = 1'b1;
        run(4'd2, 4'd5, 4'd1, 4'd2, 4, 1'b0);

        // start held through the whole SUB, including the done cycle.
        run(4'd3, 4'd9, 4'd4, 4'd6, 4, 1'b1);
        run(4'd4, 4'd1, 4'd2, 4'd3, 5 + W, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
